// File: rtl/mem_loader.sv
// mem_loader: streams load beats into instruction/data memory and holds the CPU until the session ends.
// Optional feature: define LOADER_CHECKSUM_EN to drive checksum with a running sum of written words.
module mem_loader #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 7,
    parameter int IMEM_DEPTH = 128,
    parameter int DMEM_DEPTH = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              s_sel,
    input  logic              s_addr_set,
    input  logic [ADDR_W-1:0] s_addr,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W+1:0] count,
    output logic [DATA_W-1:0] checksum
);
    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, RUN} state_t;

    // Depths carry one extra bit so a full 2^ADDR_W memory still compares correctly.
    localparam logic [ADDR_W:0] IDEPTH = (ADDR_W+1)'(IMEM_DEPTH);
    localparam logic [ADDR_W:0] DDEPTH = (ADDR_W+1)'(DMEM_DEPTH);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] iptr, dptr, addr, ptr_nxt;
    logic [ADDR_W:0]   depth, addr_inc;
    logic              fire, clr, in_range, wr;

    assign fire     = s_ready && s_valid;
    assign clr      = start && (state == IDLE || state == RUN);
    assign addr     = s_addr_set ? s_addr : (s_sel ? dptr : iptr);
    assign depth    = s_sel ? DDEPTH : IDEPTH;
    assign in_range = {1'b0, addr} < depth;
    assign wr       = fire && in_range;
    assign addr_inc = {1'b0, addr} + (ADDR_W+1)'(1);
    assign ptr_nxt  = (addr_inc >= depth) ? '0 : addr_inc[ADDR_W-1:0];

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state; handshake and hold/done decode purely from state.
    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        cpu_hold  = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE:  state_nxt = start ? LOAD : IDLE;
            LOAD: begin
                s_ready = 1'b1;
                if (s_valid && s_last) state_nxt = FLUSH;
            end
            FLUSH: state_nxt = RUN;
            RUN: begin
                cpu_hold = 1'b0;
                done     = 1'b1;
                if (start) state_nxt = LOAD;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registered memory write ports; address/data hold their last written value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
        end else begin
            imem_we <= wr && !s_sel;
            dmem_we <= wr && s_sel;
            if (wr && !s_sel) begin
                imem_addr  <= addr;
                imem_wdata <= s_data;
            end
            if (wr && s_sel) begin
                dmem_addr  <= addr;
                dmem_wdata <= s_data;
            end
        end
    end

    // Session bookkeeping: pointers, saturating write count and sticky range error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            iptr  <= '0;
            dptr  <= '0;
            count <= '0;
            err   <= 1'b0;
        end else if (clr) begin
            iptr  <= '0;
            dptr  <= '0;
            count <= '0;
            err   <= 1'b0;
        end else if (fire) begin
            if (in_range) begin
                if (s_sel) dptr <= ptr_nxt;
                else       iptr <= ptr_nxt;
                if (count != '1) count <= count + (ADDR_W+2)'(1);
            end else begin
                err <= 1'b1;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running sum of every word actually written this session.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)    checksum <= '0;
        else if (clr) checksum <= '0;
        else if (wr)  checksum <= checksum + s_data;
    end
`else
    assign checksum = '0;
`endif
endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: directed scoreboard bench for mem_loader (small IMEM to exercise wrap, 64-word DMEM for range errors).
module tb_mem_loader;
    logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic        s_valid = 1'b0, s_sel = 1'b0, s_addr_set = 1'b0, s_last = 1'b0;
    logic [6:0]  s_addr = '0;
    logic [31:0] s_data = '0;
    logic        s_ready, imem_we, dmem_we, cpu_hold, done, err;
    logic [6:0]  imem_addr, dmem_addr;
    logic [31:0] imem_wdata, dmem_wdata, checksum;
    logic [8:0]  count;

    typedef struct {logic port; logic [6:0] addr; logic [31:0] data;} wr_t;
    wr_t         exp_q[$];
    int          total = 0, bad = 0;
    logic [31:0] exp_sum;

    mem_loader #(.DATA_W(32), .ADDR_W(7), .IMEM_DEPTH(4), .DMEM_DEPTH(64)) dut (
        .clk(clk), .reset(reset), .start(start), .s_valid(s_valid), .s_ready(s_ready),
        .s_sel(s_sel), .s_addr_set(s_addr_set), .s_addr(s_addr), .s_data(s_data), .s_last(s_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .cpu_hold(cpu_hold), .done(done), .err(err), .count(count), .checksum(checksum)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] csum(input logic [31:0] s);
`ifdef LOADER_CHECKSUM_EN
        return s;
`else
        return 32'h0 & s;
`endif
    endfunction

    task automatic check_write(input logic port, input logic [6:0] a, input logic [31:0] d);
        wr_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: got port=%0d addr=%0d data=%h expected none", port, a, d);
        end else begin
            e = exp_q.pop_front();
            chk("write", {23'd0, port, a, d}, {23'd0, e.port, e.addr, e.data});
        end
    endtask

    // Monitor: every write pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (imem_we && dmem_we) chk("both_we", 64'd1, 64'd0);
        if (imem_we) check_write(1'b0, imem_addr, imem_wdata);
        if (dmem_we) check_write(1'b1, dmem_addr, dmem_wdata);
    end

    task automatic start_pulse;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_sum = '0;
    endtask

    task automatic beat(input logic sel, input logic set, input logic [6:0] a, input logic [31:0] d,
                        input logic last, input logic wr, input logic [6:0] ea);
        int n = 0;
        @(negedge clk);
        s_valid = 1'b1; s_sel = sel; s_addr_set = set; s_addr = a; s_data = d; s_last = last;
        while (!s_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("beat_ready", s_ready, 1);
        if (wr) begin
            exp_q.push_back('{sel, ea, d});
            exp_sum = exp_sum + d;
        end
        @(posedge clk);
    endtask

    task automatic end_session;
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0;
        chk("flush_we", imem_we | dmem_we, 1);
        chk("flush_hold", cpu_hold, 1);
        chk("flush_ready", s_ready, 0);
        chk("flush_done", done, 0);
        @(negedge clk);
        chk("run_hold", cpu_hold, 0);
        chk("run_done", done, 1);
        chk("run_we", imem_we | dmem_we, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        chk("rst_hold", cpu_hold, 1);
        chk("rst_ready", s_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_count", count, 0);
        chk("rst_sum", checksum, 0);
        chk("rst_we", {imem_we, dmem_we}, 0);
        chk("rst_addr", {imem_addr, dmem_addr, imem_wdata, dmem_wdata}, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_ready", s_ready, 0);

        // auto-increment into imem
        start_pulse();
        chk("load_ready", s_ready, 1);
        beat(0, 0, 0, 32'h20220002, 0, 1, 0);
        beat(0, 0, 0, 32'h00000000, 0, 1, 1);
        beat(0, 0, 0, 32'h1234ABCD, 1, 1, 2);
        end_session();
        chk("auto_count", count, 3);
        chk("auto_sum", checksum, csum(32'h3256ABCF));
        chk("auto_err", err, 0);

        // restart from RUN, explicit then auto into dmem
        start_pulse();
        chk("restart_hold", cpu_hold, 1);
        chk("restart_done", done, 0);
        chk("restart_count", count, 0);
        chk("restart_sum", checksum, 0);
        beat(1, 1, 1, 32'd2, 0, 1, 1);
        beat(1, 0, 0, 32'd7, 1, 1, 2);
        end_session();
        chk("mixed_count", count, 2);

        // out-of-range explicit address is dropped
        start_pulse();
        beat(1, 1, 100, 32'd5, 0, 0, 0);
        @(negedge clk);
        s_valid = 1'b0;
        chk("oor_err", err, 1);
        chk("oor_count", count, 0);
        chk("oor_we", dmem_we, 0);
        beat(1, 0, 0, 32'd9, 1, 1, 0);
        end_session();
        chk("oor_count_after", count, 1);
        chk("oor_err_sticky", err, 1);
        chk("oor_sum", checksum, csum(32'd9));

        // imem wraps at depth 4
        start_pulse();
        chk("wrap_err_clr", err, 0);
        for (int i = 0; i < 5; i++) beat(0, 0, 0, 32'h10 + i, i == 4, 1, 7'(i % 4));
        end_session();
        chk("wrap_err", err, 0);
        chk("wrap_count", count, 5);
        chk("wrap_sum", checksum, csum(32'h5A));

        // modular checksum
        start_pulse();
        beat(0, 0, 0, 32'hFFFFFFFF, 0, 1, 0);
        beat(0, 0, 0, 32'h00000002, 1, 1, 1);
        end_session();
        chk("mod_sum", checksum, csum(32'h00000001));

        // reload clears checksum, then reset mid-session
        start_pulse();
        chk("reload_sum", checksum, 0);
        beat(0, 0, 0, 32'hA1, 0, 1, 0);
        beat(0, 0, 0, 32'hA2, 0, 1, 1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_we", imem_we, 0);
        chk("mid_rst_addr", {imem_addr, imem_wdata}, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_hold", cpu_hold, 1);
        chk("mid_rst_ready", s_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_rst_ready", s_ready, 0);
        chk("post_rst_count", count, 0);
        s_valid = 1'b0;
        @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_loader.md
# mem_loader

Parametrised boot/load sequencer for the MIPS core. It accepts a valid/ready stream of load beats and writes each one into either instruction memory or data memory, using an explicit or auto-incremented address. It holds the CPU stalled until the load session ends, then releases it. It sits between the test/boot source and the `main` memory write ports, replacing hand-driven instruction, data, address and write-enable stimulus.

## Interface
- DATA_W, 32, memory word width
- ADDR_W, 7, memory address width
- IMEM_DEPTH, 128, valid instruction-memory words (≤ 2^ADDR_W)
- DMEM_DEPTH, 128, valid data-memory words (≤ 2^ADDR_W)

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin load session (sampled in IDLE or RUN)
- s_valid  in  1  load beat valid
- s_ready  out  1  beat accepted when s_valid && s_ready
- s_sel  in  1  0 = instruction memory, 1 = data memory
- s_addr_set  in  1  1 = use s_addr; 0 = auto-increment pointer of selected memory
- s_addr  in  ADDR_W  explicit address
- s_data  in  DATA_W  word to write
- s_last  in  1  final beat of session
- imem_we / imem_addr / imem_wdata  out  1 / ADDR_W / DATA_W  instruction-memory write port
- dmem_we / dmem_addr / dmem_wdata  out  1 / ADDR_W / DATA_W  data-memory write port
- cpu_hold  out  1  stalls CPU while high
- done  out  1  session complete, sticky until next start
- err  out  1  sticky out-of-range flag, cleared by start
- count  out  ADDR_W+2  words actually written this session
- checksum  out  DATA_W  see Configuration

## Operation
- States: IDLE, LOAD, FLUSH, RUN.
- Reset values: state = IDLE; cpu_hold = 1; s_ready, done, err, both we = 0; all addresses, wdata, count, checksum and both pointers = 0.
- IDLE → LOAD on start.
- LOAD: s_ready = 1. Each accepted beat:
  - Address = s_addr_set ? s_addr : ptr[s_sel].
  - If address < DEPTH of the selected memory: one-cycle write on the selected port; count += 1; ptr[s_sel] = address+1, wrapping to 0 at DEPTH.
  - Else: no write; err = 1; pointer and count unchanged.
  - The unselected memory port's we stays 0.
- Accepted beat with s_last: LOAD → FLUSH.
- FLUSH: s_ready = 0 for one cycle, then → RUN.
- RUN: cpu_hold = 0, done = 1.
- RUN → LOAD on start: cpu_hold = 1 and done = 0 from the next edge. Pointers, count, err and checksum clear to 0.
- start while in LOAD or FLUSH is ignored.
- count saturates at all-ones.

## Timing
- Beat accepted at edge k: we, addr and wdata are registered at edge k and valid in cycle k…k+1. Exactly one cycle of we per written beat.
- Back-to-back beats: one write per cycle, no bubbles.
- Last beat accepted at edge k:
  - FLUSH during k…k+1.
  - RUN at edge k+1: cpu_hold falls and done rises there, one cycle after the last we pulse starts.
  - The last write therefore completes before the CPU leaves hold.
- s_ready is combinational from state only, never from s_valid.
- Reset asserted mid-session: immediate return to reset values. Partially loaded memory contents are not rolled back. A new start is required.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - checksum = running sum modulo 2^DATA_W of every written s_data; dropped beats are excluded.
  - Cleared on reset and on start; held stable in RUN.
- Not defined: checksum tied to 0, no adder logic; port still present.

## Test plan
- Auto-increment: start; 3 beats s_sel=0, s_addr_set=0, data 0x20220002, 0x00000000, 0x1234ABCD (last on 3rd) -> imem writes at 0, 1, 2 on consecutive cycles; count = 3; cpu_hold falls 1 cycle after the 3rd we; done = 1.
- Mixed and explicit: beat s_sel=1, s_addr_set=1, s_addr=1, data 2; then s_sel=1 auto, data 7, last -> dmem writes (1, 2) then (2, 7); imem_we never asserted.
- Out of range: DMEM_DEPTH=64, explicit s_addr=100 -> no dmem_we; err = 1; count unchanged; next auto beat writes address 0.
- Wrap: IMEM_DEPTH=4, 5 auto beats -> addresses 0, 1, 2, 3, 0; err = 0.
- Reset mid-load: reset asserted after the 2nd of 4 beats -> all outputs at reset values immediately; cpu_hold = 1; further s_valid ignored until start.
- With LOADER_CHECKSUM_EN: data 0xFFFFFFFF, 0x00000002 -> checksum 0x00000001; without the macro -> checksum 0; reload via start from RUN clears it.
